// File: rtl/cmp_sar_search_if.sv
// ---------------------------------------------------------------------------
// cmp_sar_search_if
//   Bundles the search handshake and comparator-facing signals of
//   cmp_sar_search.
//
//   Signals
//     start     search request (sampled by the controller only when idle)
//     cmp_code  comparator result: 10 A>B, 01 A<B, 00 A==B, 11 illegal
//     cmp_en    comparator enable (high only while probing)
//     cmp_b     probe value driven to the comparator B operand
//     busy      search in progress
//     done      one-cycle completion pulse
//     found     last search ended on equality
//     err       last search ended inconsistently
//     result    recovered value (valid when found)
//
//   Modports
//     master    requester + comparator side (drives start, cmp_code)
//     slave     the search controller
// ---------------------------------------------------------------------------
interface cmp_sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [1:0]       cmp_code;
    logic             cmp_en;
    logic [WIDTH-1:0] cmp_b;
    logic             busy;
    logic             done;
    logic             found;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output cmp_code,
        input  cmp_en,
        input  cmp_b,
        input  busy,
        input  done,
        input  found,
        input  err,
        input  result
    );

    modport slave (
        input  start,
        input  cmp_code,
        output cmp_en,
        output cmp_b,
        output busy,
        output done,
        output found,
        output err,
        output result
    );
endinterface

// File: rtl/cmp_sar_search.sv
// ---------------------------------------------------------------------------
// cmp_sar_search
//   Successive-approximation controller. The unknown value sits on the
//   comparator A input; this block drives the comparator enable and the
//   B operand, binary-searches [0, 2^WIDTH-1] from the returned compare
//   code, and reports the value once the comparator signals equality.
//   An inconsistent code sequence (or the illegal code 11) ends the
//   search with err.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; aborts any search, no done pulse
//     bus    cmp_sar_search_if.slave (start, cmp_code in; cmp_en, cmp_b,
//            busy, done, found, err, result out)
//
//   Configuration macro
//     CMP_SAR_CODE_PIPE_EN  register cmp_code at the end of each PROBE
//                           cycle and evaluate it in an extra WAIT cycle
//                           (2 cycles per probe). Undefined: the code is
//                           evaluated directly at the end of PROBE.
//
//   state | meaning
//   IDLE  | waiting for start; found/err/result hold the last outcome
//   PROBE | cmp_en=1, cmp_b=mid; code evaluated here unless pipelined
//   WAIT  | pipelined build only: probe held, registered code evaluated
//   DONE  | one-cycle done pulse, start ignored
// ---------------------------------------------------------------------------
module cmp_sar_search #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cmp_sar_search_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PROBE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef CMP_SAR_CODE_PIPE_EN
    localparam logic [1:0] S_EVAL  = S_WAIT;
`else
    localparam logic [1:0] S_EVAL  = S_PROBE;
`endif

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_cmp_b;
    logic             r_found;
    logic             r_err;
    logic [WIDTH-1:0] r_result;
`ifdef CMP_SAR_CODE_PIPE_EN
    logic [1:0]       r_code;
`endif

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mid;
    logic [WIDTH:0]   w_mid_p1;
    logic [WIDTH:0]   w_mid_m1;
    logic             w_up_ok;
    logic             w_dn_ok;
    logic [1:0]       w_code;
    logic             w_eval_now;
    logic             w_hit;
    logic             w_fail;
    logic             w_go_up;
    logic             w_probing;

    // Sum formed one bit wider so lo+hi never wraps.
    assign w_sum    = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid    = w_sum[WIDTH:1];
    assign w_mid_p1 = {1'b0, w_mid} + ONE_X;
    assign w_mid_m1 = {1'b0, w_mid} - ONE_X;

    // The max/zero guards come first; the widened compares then never
    // see a wrapped value.
    assign w_up_ok  = (w_mid != MAX_VAL)       && (w_mid_p1 <= {1'b0, r_hi});
    assign w_dn_ok  = (w_mid != {WIDTH{1'b0}}) && (w_mid_m1 >= {1'b0, r_lo});

`ifdef CMP_SAR_CODE_PIPE_EN
    assign w_code = r_code;
`else
    assign w_code = bus.cmp_code;
`endif

    assign w_eval_now = (r_state == S_EVAL);

    always_comb begin
        w_hit   = 1'b0;
        w_fail  = 1'b0;
        w_go_up = 1'b0;
        case (w_code)
            2'b00: w_hit = 1'b1;
            2'b10: begin
                if (w_up_ok) w_go_up = 1'b1;
                else         w_fail  = 1'b1;
            end
            2'b01: begin
                if (!w_dn_ok) w_fail = 1'b1;
            end
            default: w_fail = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_cmp_b  <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
`ifdef CMP_SAR_CODE_PIPE_EN
            r_code   <= 2'b00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_lo    <= '0;
                        r_hi    <= MAX_VAL;
                        r_found <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    // Remember the probe so cmp_b holds once cmp_en drops.
                    r_cmp_b <= w_mid;
`ifdef CMP_SAR_CODE_PIPE_EN
                    r_code  <= bus.cmp_code;
                    r_state <= S_WAIT;
`endif
                end
                S_WAIT:  r_state <= S_PROBE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Outcome of the current probe; overrides the state step above.
            if (w_eval_now) begin
                if (w_hit) begin
                    r_result <= w_mid;
                    r_found  <= 1'b1;
                    r_state  <= S_DONE;
                end else if (w_fail) begin
                    r_err    <= 1'b1;
                    r_state  <= S_DONE;
                end else if (w_go_up) begin
                    r_lo     <= w_mid_p1[WIDTH-1:0];
                    r_state  <= S_PROBE;
                end else begin
                    r_hi     <= w_mid_m1[WIDTH-1:0];
                    r_state  <= S_PROBE;
                end
            end
        end
    end

    assign w_probing  = (r_state == S_PROBE) || (r_state == S_WAIT);

    assign bus.cmp_en = w_probing;
    // lo/hi only move at the end of a probe, so mid is stable through WAIT.
    assign bus.cmp_b  = w_probing ? w_mid : r_cmp_b;
    assign bus.busy   = w_probing;
    assign bus.done   = (r_state == S_DONE);
    assign bus.found  = r_found;
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule

// File: tb/tb_cmp_sar_search.sv
module tb_cmp_sar_search;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef CMP_SAR_CODE_PIPE_EN
    localparam int P = 2;
`else
    localparam int P = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmp_sar_search_if #(.WIDTH(WIDTH)) bus ();

    cmp_sar_search #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Comparator model: mode 0 honest, 1 stuck at 01, 2 stuck at 11.
    int a_val = 0;
    int mode  = 0;
    assign bus.cmp_code = (mode == 1) ? 2'b01 :
                          (mode == 2) ? 2'b11 :
                          (a_val > int'(bus.cmp_b)) ? 2'b10 :
                          (a_val < int'(bus.cmp_b)) ? 2'b01 : 2'b00;

    // Model output for the search about to be launched (written by stimulus).
    int m_probes[$];
    bit m_found;
    bit m_err;
    int m_res;
    int lit_q[$];
    int lit_res;
    int seq_req = 0;

    // Compare-process state.
    int n_pass = 0;
    int n_total = 0;
    int n_tmo = 0;
    int done_cnt = 0;
    int seq_seen = 0;
    bit active = 0;
    int cyc = 0;
    int c_probes[$];
    bit c_found, c_err;
    int c_res, c_lit_res;
    int c_lit[$];
    int obs[$];
    bit cur_found = 0, cur_err = 0;
    int cur_res = 0, last_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Binary search from the comparator's point of view, plain integers.
    task automatic build_model(input int a, input int md);
        int lo, hi, mid;
        lo = 0; hi = MAXV;
        m_probes.delete();
        m_found = 0; m_err = 0; m_res = 0;
        while (m_probes.size() < 2 * WIDTH + 4) begin
            mid = (lo + hi) / 2;
            m_probes.push_back(mid);
            if (md == 2) begin m_err = 1; break; end
            if (md == 0 && a == mid) begin m_found = 1; m_res = mid; break; end
            if (md == 0 && a > mid) begin
                if (mid == MAXV || mid + 1 > hi) begin m_err = 1; break; end
                lo = mid + 1;
            end else begin
                if (mid == 0 || mid - 1 < lo) begin m_err = 1; break; end
                hi = mid - 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (seq_req != seq_seen) begin
                seq_seen  = seq_req;
                active    = 1;
                cyc       = 0;
                c_probes  = m_probes;
                c_found   = m_found;
                c_err     = m_err;
                c_res     = m_res;
                c_lit     = lit_q;
                c_lit_res = lit_res;
                obs.delete();
            end
            if (!rst_n) begin
                active = 0;
                cur_found = 0; cur_err = 0; cur_res = 0; last_b = 0;
                chk("rst_cmp_en", int'(bus.cmp_en), 0);
                chk("rst_cmp_b",  int'(bus.cmp_b),  0);
                chk("rst_busy",   int'(bus.busy),   0);
                chk("rst_done",   int'(bus.done),   0);
                chk("rst_found",  int'(bus.found),  0);
                chk("rst_err",    int'(bus.err),    0);
                chk("rst_result", int'(bus.result), 0);
            end else if (active) begin
                if (cyc < c_probes.size() * P) begin
                    chk("probe_en",     int'(bus.cmp_en), 1);
                    chk("probe_b",      int'(bus.cmp_b),  c_probes[cyc / P]);
                    chk("probe_busy",   int'(bus.busy),   1);
                    chk("probe_done",   int'(bus.done),   0);
                    chk("probe_found",  int'(bus.found),  0);
                    chk("probe_err",    int'(bus.err),    0);
                    chk("probe_result", int'(bus.result), cur_res);
                    if (cyc % P == 0) obs.push_back(int'(bus.cmp_b));
                end else begin
                    chk("end_done",   int'(bus.done),   1);
                    chk("end_busy",   int'(bus.busy),   0);
                    chk("end_en",     int'(bus.cmp_en), 0);
                    chk("end_found",  int'(bus.found),  int'(c_found));
                    chk("end_err",    int'(bus.err),    int'(c_err));
                    chk("end_result", int'(bus.result), c_found ? c_res : cur_res);
                    if (c_lit.size() > 0) begin
                        chk("lit_probe_count", obs.size(), c_lit.size());
                        for (int i = 0; i < c_lit.size() && i < obs.size(); i++)
                            chk("lit_probe", obs[i], c_lit[i]);
                    end
                    if (c_lit_res >= 0) chk("lit_result", int'(bus.result), c_lit_res);
                    cur_found = c_found;
                    cur_err   = c_err;
                    if (c_found) cur_res = c_res;
                    last_b = c_probes[c_probes.size() - 1];
                    active = 0;
                    done_cnt++;
                end
                cyc++;
            end else begin
                chk("idle_en",     int'(bus.cmp_en), 0);
                chk("idle_busy",   int'(bus.busy),   0);
                chk("idle_done",   int'(bus.done),   0);
                chk("idle_found",  int'(bus.found),  int'(cur_found));
                chk("idle_err",    int'(bus.err),    int'(cur_err));
                chk("idle_result", int'(bus.result), cur_res);
                chk("idle_cmp_b",  int'(bus.cmp_b),  last_b);
            end
        end
    end

    // ign_cyc >= 0: pulse start during that cycle of the search (0 = first probe).
    // rst_cyc >= 0: assert rst_n that many cycles after the search begins.
    task automatic run_search(input int a, input int md, input int ign_cyc, input int rst_cyc);
        int target;
        bit got;
        build_model(a, md);
        @(negedge clk);
        a_val = a;
        mode  = md;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        target = done_cnt + 1;
        seq_req++;
        if (ign_cyc >= 0) begin
            repeat (ign_cyc + 1) @(negedge clk);
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        if (rst_cyc >= 0) begin
            repeat (rst_cyc) @(posedge clk);
            #2 rst_n = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #2 rst_n = 1'b1;
            repeat (3) @(posedge clk);
        end else begin
            got = 0;
            for (int i = 0; i < 2 * (WIDTH + 2) + 6; i++) begin
                if (done_cnt >= target) begin got = 1; break; end
                @(posedge clk);
            end
            if (!got) begin
                n_tmo++;
                $display("FAIL done_timeout: no done pulse for A=%0d mode=%0d", a, md);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        lit_res = -1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        lit_q = '{7, 11};          lit_res = 11; run_search(11, 0, -1, -1);
        lit_q = '{7, 3, 1, 0};     lit_res = 0;  run_search(0,  0, -1, -1);
        lit_q = '{7, 11, 13, 14, 15}; lit_res = 15; run_search(15, 0, -1, -1);
        lit_q = '{7, 3, 1, 0};     lit_res = 15; run_search(9,  1, -1, -1);
        lit_q = '{7};              lit_res = 15; run_search(4,  2, 0,  -1);
        lit_q.delete();            lit_res = -1;
        run_search(5, 0, -1, 1);
        lit_q = '{7, 11};          lit_res = 11; run_search(11, 0, -1, -1);
        lit_q.delete();            lit_res = -1;
        run_search(5, 0, 3 * P, -1);
        run_search(0, 0, 2, -1);
        run_search(6, 0, -1, -1);
        run_search(9, 0, -1, -1);
        run_search(14, 0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total + n_tmo);
        $finish;
    end

endmodule
